// File: rtl/sync_fifo_ext.sv
// Synchronous FIFO with threshold flags, sticky overflow/underflow and
// selectable registered-read or first-word-fall-through output.
module sync_fifo_ext #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 2,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  clr_err,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   LVL_FULL = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   LVL_AF   = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0]   LVL_AE   = (ADDR_WIDTH+1)'(AE_LEVEL);
    localparam logic [ADDR_WIDTH:0]   LVL_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  push_ok;
    logic                  pop_ok;

    // Gating by full/empty resolves the simultaneous cases: when full the
    // pop wins, when empty the push wins.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign empty        = (level == '0);
    assign full         = (level == LVL_FULL);
    assign almost_empty = (level <= LVL_AE);
    assign almost_full  = (level >= LVL_AF);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)
                rd_ptr <= rd_ptr + PTR_ONE;
            if (push_ok && !pop_ok)
                level <= level + LVL_ONE;
            else if (pop_ok && !push_ok)
                level <= level - LVL_ONE;
            // A fresh error event takes priority over a clear in the same cycle.
            if (push && full)
                overflow <= 1'b1;
            else if (clr_err)
                overflow <= 1'b0;
            if (pop && empty)
                underflow <= 1'b1;
            else if (clr_err)
                underflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n && push_ok)
            mem[wr_ptr] <= data_in;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Masking while empty keeps unwritten storage off the output.
            assign data_out = empty ? '0 : mem[rd_ptr];
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] dout_q;
            always_ff @(posedge clk or posedge rst_n) begin
                if (rst_n)
                    dout_q <= '0;
                else if (pop_ok)
                    dout_q <= mem[rd_ptr];
            end
            assign data_out = dout_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_ext.sv
// Directed bench for sync_fifo_ext: registered-read instance plus a
// first-word-fall-through instance sharing clock, reset and clr_err.
module tb_sync_fifo_ext;

    logic       clk;
    logic       rst_n;
    logic       clr_err;
    logic       push, pop;
    logic [7:0] data_in, data_out;
    logic       empty, full, almost_empty, almost_full, overflow, underflow;
    logic [4:0] level;
    logic       push1, pop1;
    logic [7:0] data_in1, data_out1;
    logic       empty1, full1, almost_empty1, almost_full1, overflow1, underflow1;
    logic [4:0] level1;

    int errors = 0;
    int checks = 0;

    sync_fifo_ext #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .clr_err(clr_err),
        .data_in(data_in), .data_out(data_out), .empty(empty), .full(full),
        .almost_empty(almost_empty), .almost_full(almost_full), .level(level),
        .overflow(overflow), .underflow(underflow)
    );

    sync_fifo_ext #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .push(push1), .pop(pop1), .clr_err(clr_err),
        .data_in(data_in1), .data_out(data_out1), .empty(empty1), .full(full1),
        .almost_empty(almost_empty1), .almost_full(almost_full1), .level(level1),
        .overflow(overflow1), .underflow(underflow1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        push = 0; pop = 0; push1 = 0; pop1 = 0; clr_err = 0;
        data_in = '0; data_in1 = '0;
        rst_n = 1;
        #2;
        rst_n = 0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1; push = 0; pop = 0; push1 = 0; pop1 = 0; clr_err = 0;
        data_in = '0; data_in1 = '0;
        tick();
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL rst_level got %0d exp 0", level); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty got %b exp 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL rst_full got %b exp 0", full); end
        checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL rst_ae got %b exp 1", almost_empty); end
        checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL rst_af got %b exp 0", almost_full); end
        checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL rst_err got %b%b exp 00", overflow, underflow); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL rst_dout got %h exp 00", data_out); end
        checks++; if (data_out1 !== 8'h00) begin errors++; $display("FAIL rst_dout1 got %h exp 00", data_out1); end
        rst_n = 0;
        tick();
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 16; i++) begin
            push = 1; data_in = 8'(i + 1);
            tick();
            if (i == 14) begin
                checks++; if (full !== 1'b0 || level !== 5'd15) begin errors++; $display("FAIL fill15 got full=%b level=%0d exp full=0 level=15", full, level); end
            end
        end
        checks++; if (full !== 1'b1 || level !== 5'd16) begin errors++; $display("FAIL fill16 got full=%b level=%0d exp full=1 level=16", full, level); end
        data_in = 8'h11;
        tick();
        push = 0;
        checks++; if (overflow !== 1'b1 || level !== 5'd16) begin errors++; $display("FAIL ovf17 got ovf=%b level=%0d exp ovf=1 level=16", overflow, level); end
        for (int i = 0; i < 16; i++) begin
            pop = 1;
            tick();
            checks++; if (data_out !== 8'(i + 1)) begin errors++; $display("FAIL drain[%0d] got %h exp %h", i, data_out, 8'(i + 1)); end
        end
        pop = 0;
        checks++; if (empty !== 1'b1 || level !== 5'd0) begin errors++; $display("FAIL drained got empty=%b level=%0d exp empty=1 level=0", empty, level); end
        pop = 1;
        tick();
        pop = 0;
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL udf got %b exp 1", underflow); end
        checks++; if (data_out !== 8'h10) begin errors++; $display("FAIL dout_hold got %h exp 10", data_out); end
        clr_err = 1;
        tick();
        clr_err = 0;
        checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL clr got %b%b exp 00", overflow, underflow); end
        clr_err = 1; pop = 1;
        tick();
        clr_err = 0; pop = 0;
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL clr_vs_udf got %b exp 1", underflow); end
    endtask

    task automatic test_thresholds();
        do_reset();
        for (int i = 1; i <= 14; i++) begin
            push = 1; data_in = 8'(i);
            tick();
            if (i == 2) begin
                checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL ae_at2 got %b exp 1", almost_empty); end
            end
            if (i == 3) begin
                checks++; if (almost_empty !== 1'b0) begin errors++; $display("FAIL ae_at3 got %b exp 0", almost_empty); end
            end
            if (i == 13) begin
                checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL af_at13 got %b exp 0", almost_full); end
            end
        end
        push = 0;
        checks++; if (almost_full !== 1'b1 || level !== 5'd14) begin errors++; $display("FAIL af_at14 got af=%b level=%0d exp af=1 level=14", almost_full, level); end
        pop = 1;
        tick();
        pop = 0;
        checks++; if (almost_full !== 1'b0 || level !== 5'd13) begin errors++; $display("FAIL af_pop got af=%b level=%0d exp af=0 level=13", almost_full, level); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            push = 1; data_in = 8'(8'h20 + i);
            tick();
        end
        push = 1; pop = 1; data_in = 8'hAA;
        tick();
        push = 0; pop = 0;
        checks++; if (level !== 5'd15 || overflow !== 1'b1) begin errors++; $display("FAIL full_pp got level=%0d ovf=%b exp level=15 ovf=1", level, overflow); end
        checks++; if (data_out !== 8'h20) begin errors++; $display("FAIL full_pp_dout got %h exp 20", data_out); end
        for (int i = 1; i < 16; i++) begin
            pop = 1;
            tick();
            checks++; if (data_out !== 8'(8'h20 + i)) begin errors++; $display("FAIL no_aa[%0d] got %h exp %h", i, data_out, 8'(8'h20 + i)); end
        end
        pop = 0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL sim_empty got %b exp 1", empty); end
        push = 1; pop = 1; data_in = 8'h55;
        tick();
        push = 0; pop = 0;
        checks++; if (level !== 5'd1 || underflow !== 1'b1) begin errors++; $display("FAIL empty_pp got level=%0d udf=%b exp level=1 udf=1", level, underflow); end
        pop = 1;
        tick();
        pop = 0;
        checks++; if (data_out !== 8'h55 || level !== 5'd0) begin errors++; $display("FAIL pop55 got dout=%h level=%0d exp dout=55 level=0", data_out, level); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            push = 1; data_in = 8'(i);
            tick();
        end
        for (int i = 0; i < 40; i++) begin
            push = 1; pop = 1; data_in = 8'(i + 5);
            tick();
            checks++; if (level !== 5'd5 || data_out !== 8'(i)) begin errors++; $display("FAIL wrap[%0d] got level=%0d dout=%h exp level=5 dout=%h", i, level, data_out, 8'(i)); end
        end
        push = 0; pop = 0;
    endtask

    task automatic test_fwft();
        do_reset();
        push1 = 1; data_in1 = 8'h3C;
        tick();
        push1 = 0;
        checks++; if (data_out1 !== 8'h3C || empty1 !== 1'b0) begin errors++; $display("FAIL fwft_first got dout=%h empty=%b exp dout=3c empty=0", data_out1, empty1); end
        push1 = 1; data_in1 = 8'h3D;
        tick();
        push1 = 0;
        checks++; if (data_out1 !== 8'h3C || level1 !== 5'd2) begin errors++; $display("FAIL fwft_hold got dout=%h level=%0d exp dout=3c level=2", data_out1, level1); end
        pop1 = 1;
        tick();
        pop1 = 0;
        checks++; if (data_out1 !== 8'h3D) begin errors++; $display("FAIL fwft_pop got %h exp 3d", data_out1); end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            push = 1; data_in = 8'(8'h70 + i);
            tick();
        end
        push = 0; pop = 1;
        tick();
        pop = 0;
        checks++; if (level !== 5'd7 || data_out !== 8'h70) begin errors++; $display("FAIL pre_rst got level=%0d dout=%h exp level=7 dout=70", level, data_out); end
        #2;
        rst_n = 1;
        #1;
        checks++; if (level !== 5'd0 || empty !== 1'b1 || data_out !== 8'h00) begin errors++; $display("FAIL async_rst got level=%0d empty=%b dout=%h exp level=0 empty=1 dout=00", level, empty, data_out); end
        tick();
        rst_n = 0;
        pop = 1;
        tick();
        pop = 0;
        checks++; if (underflow !== 1'b1 || level !== 5'd0) begin errors++; $display("FAIL post_rst_pop got udf=%b level=%0d exp udf=1 level=0", underflow, level); end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_thresholds();
        test_simultaneous();
        test_wrap();
        test_fwft();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sync_fifo_ext.md
SYNC_FIFO_EXT -- requirements
Module: sync_fifo_ext

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 4, giving depth DEPTH = 2^ADDR_WIDTH entries.
REQ-003 The block SHALL have parameter AF_LEVEL, default DEPTH-2, the almost_full threshold (1..DEPTH-1).
REQ-004 The block SHALL have parameter AE_LEVEL, default 2, the almost_empty threshold (0..DEPTH-2).
REQ-005 The block SHALL have parameter FWFT, default 0: 0 = registered-read mode, 1 = first-word-fall-through mode.
REQ-006 clk  input  1  clock; all state changes on rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-high.
REQ-008 push  input  1  write request.
REQ-009 pop  input  1  read request.
REQ-010 clr_err  input  1  synchronous clear of the sticky error flags.
REQ-011 data_in  input  DATA_WIDTH  write data.
REQ-012 data_out  output  DATA_WIDTH  read data.
REQ-013 empty / full  output  1 each  level==0 / level==DEPTH.
REQ-014 almost_empty / almost_full  output  1 each  level<=AE_LEVEL / level>=AF_LEVEL.
REQ-015 level  output  ADDR_WIDTH+1  current number of stored words, 0..DEPTH.
REQ-016 overflow / underflow  output  1 each  sticky error flags.

Function
REQ-017 The FIFO SHALL store all DEPTH entries; full SHALL assert only at level==DEPTH.
REQ-018 A push SHALL be accepted iff push && !full; an accepted push writes data_in at the write pointer and increments it modulo DEPTH.
REQ-019 A pop SHALL be accepted iff pop && !empty; an accepted pop increments the read pointer modulo DEPTH.
REQ-020 level SHALL be +1 on push-only accept, -1 on pop-only accept, unchanged when both or neither are accepted.
REQ-021 When full and push && pop, the pop SHALL be accepted and the push rejected (level becomes DEPTH-1, overflow set).
REQ-022 When empty and push && pop, the push SHALL be accepted and the pop rejected (level becomes 1, underflow set).
REQ-023 empty, full, almost_empty, almost_full SHALL be decoded from the level register, updating on the same edge as level.
REQ-024 FWFT=0: on an accepted pop, data_out SHALL be loaded with the word at the read pointer on that edge (1-cycle latency); otherwise data_out holds.
REQ-025 FWFT=1: data_out SHALL present the word at the read pointer whenever !empty with no pop needed; the first pushed word appears the cycle after its push; a pop advances to the next word next cycle; data_out is don't-care while empty.
REQ-026 overflow SHALL set on the edge after any cycle with push && full; underflow SHALL set on the edge after any cycle with pop && empty.
REQ-027 clr_err SHALL clear both error flags on the next edge; a new error event in the same cycle SHALL win (flag stays set).
REQ-028 Rejected requests SHALL not modify memory, pointers, level or data_out.
REQ-029 Pointer wrap SHALL be seamless; no entry loss or duplication across wrap.

Reset
REQ-030 While rst_n is high, level, both pointers, overflow, underflow and data_out SHALL be 0 immediately, regardless of clk.
REQ-031 After reset: empty=1, full=0, almost_empty=1, almost_full=0; memory contents are not reset and SHALL never be visible before being written.
REQ-032 Reset asserted mid-operation SHALL discard all stored words; the first pop after release with no push SHALL set underflow.

Verification (DEPTH=16, AF_LEVEL=14, AE_LEVEL=2)
REQ-033 FWFT=0: push 0x01..0x10 -> full=1 after 16th push, level=16; 17th push -> overflow=1, level stays 16; 16 pops -> data_out 0x01..0x10 in order, each 1 cycle after pop, then empty=1.
REQ-034 Thresholds: push 2 words -> almost_empty=1; 3rd -> almost_empty=0; 14th -> almost_full=1; pop one -> almost_full=0.
REQ-035 Simultaneous: at level=16 assert push+pop with data_in 0xAA -> level=15, overflow=1, 0xAA never read; at level=0 push+pop with 0x55 -> level=1, underflow=1, next pop returns 0x55.
REQ-036 Wrap: 40 cycles of continuous push+pop at level 5 with incrementing data -> level stays 5, output sequence strictly incrementing, no gaps.
REQ-037 FWFT=1: push 0x3C into empty FIFO -> data_out=0x3C next cycle with no pop; push 0x3D then pop -> data_out=0x3D next cycle.
REQ-038 Reset/clear: set overflow, pulse clr_err -> overflow=0; fill 7 words, assert rst_n asynchronously mid-cycle -> level=0, empty=1, data_out=0 immediately.
